mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory access unit: access sizes,
// FSM states, byte-lane selection and store-data replication.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Size code 3 behaves exactly like a word access.
    function automatic logic [3:0] f_byte_sel(input logic [1:0] size, input logic [1:0] low);
        case (size)
            SZ_BYTE: return 4'b0001 << low;
            SZ_HALF: return low[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] low);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return low[0];
            default: return low != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] f_align_low(input logic [1:0] size, input logic [1:0] low);
        case (size)
            SZ_BYTE: return low;
            SZ_HALF: return {low[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word lane out of a memory word and
// zero- or sign-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[7:0];
        case (i_addr)
            2'd0: w_byte = i_data[7:0];
            2'd1: w_byte = i_data[15:8];
            2'd2: w_byte = i_data[23:16];
            2'd3: w_byte = i_data[31:24];
            default: w_byte = i_data[7:0];
        endcase
        w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];

        o_result = i_data;
        case (i_size)
            SZ_BYTE: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_result = {{16{i_signed & w_half[15]}}, w_half};
            default: o_result = i_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a valid/ready request port and a one-cycle-latency
// word memory. Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_signed,
    input  logic [MEM_ADDR_BITS+1:0]   req_addr,
    input  logic [MEM_DATA_BITS-1:0]   req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [MEM_DATA_BITS-1:0]   rsp_rdata,
    output logic                       rsp_misalign,
    output logic [MEM_ADDR_BITS-1:0]   mem_addr,
    output logic [MEM_DATA_BITS-1:0]   mem_data_in,
    output logic [3:0]                 mem_sel,
    output logic                       mem_str,
    output logic                       mem_ld,
    input  logic [MEM_DATA_BITS-1:0]   mem_data_out
);

    state_t                     r_state;
    logic                       r_we;
    logic [1:0]                 r_size;
    logic                       r_signed;
    logic [MEM_ADDR_BITS+1:0]   r_addr;
    logic                       r_rsp_valid;
    logic [MEM_DATA_BITS-1:0]   r_rsp_rdata;
    logic                       r_rsp_misalign;
    logic [MEM_DATA_BITS-1:0]   r_mem_data_in;
    logic [3:0]                 r_mem_sel;
    logic                       r_mem_str;
    logic                       r_mem_ld;

    logic [MEM_ADDR_BITS+1:0]   w_addr;
    logic [31:0]                w_load_result;
    logic                       w_fault;

    // Low address bits a size cannot use are dropped before registering.
    assign w_addr = {req_addr[MEM_ADDR_BITS+1:2], f_align_low(req_size, req_addr[1:0])};

`ifdef MISALIGN_TRAP_EN
    assign w_fault = f_misaligned(req_size, req_addr[1:0]);
`else
    assign w_fault = 1'b0;
`endif

    load_align u_load_align (
        .i_data   (mem_data_out),
        .i_addr   (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_result (w_load_result)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state        <= IDLE;
            r_we           <= 1'b0;
            r_size         <= 2'd0;
            r_signed       <= 1'b0;
            r_addr         <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_misalign <= 1'b0;
            r_mem_data_in  <= '0;
            r_mem_sel      <= 4'b0000;
            r_mem_str      <= 1'b0;
            r_mem_ld       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= w_addr;
                        if (w_fault) begin
                            r_state        <= RESP;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_misalign <= 1'b1;
                            r_rsp_rdata    <= '0;
                        end else begin
                            r_state       <= ISSUE;
                            r_mem_sel     <= f_byte_sel(req_size, w_addr[1:0]);
                            r_mem_data_in <= f_store_data(req_size, req_wdata);
                            r_mem_str     <= req_we;
                            r_mem_ld      <= !req_we;
                        end
                    end
                end
                ISSUE: begin
                    r_mem_sel     <= 4'b0000;
                    r_mem_data_in <= '0;
                    r_mem_str     <= 1'b0;
                    r_mem_ld      <= 1'b0;
                    if (r_we) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                // Memory read data is valid during this state.
                WAIT: begin
                    r_rsp_rdata <= w_load_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid    <= 1'b0;
                        r_rsp_misalign <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_misalign = r_rsp_misalign;
    assign mem_addr     = r_addr[MEM_ADDR_BITS+1:2];
    assign mem_data_in  = r_mem_data_in;
    assign mem_sel      = r_mem_sel;
    assign mem_str      = r_mem_str;
    assign mem_ld       = r_mem_ld;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array reference model,
// directed cases with literal expectations, then randomized traffic.
module tb_mem_access_unit;

    localparam int AB = 10;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_signed = 1'b0;
    logic [AB+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_misalign;
    logic [AB-1:0] mem_addr;
    logic [31:0]   mem_data_in;
    logic [3:0]    mem_sel;
    logic          mem_str;
    logic          mem_ld;
    logic [31:0]   memDataOut = '0;

    int testsRun = 0;
    int testsFailed = 0;
    bit monEn = 1'b0;
    bit inFlight = 1'b0;

    logic [7:0]  refMem [0:4095];
    logic [31:0] memArr [0:1023];

    logic [31:0]   dutRdata, dutDataIn;
    logic [3:0]    dutSel;
    logic [AB-1:0] dutAddr;
    logic          dutMis;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_ADDR_BITS(AB), .MEM_DATA_BITS(32)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_sel      (mem_sel),
        .mem_str      (mem_str),
        .mem_ld       (mem_ld),
        .mem_data_out (memDataOut)
    );

    // Word memory with byte enables, registered sel-masked read data.
    always @(posedge clk) begin
        if (mem_ld) begin
            for (int i = 0; i < 4; i++)
                memDataOut[8*i +: 8] <= mem_sel[i] ? memArr[mem_addr][8*i +: 8] : 8'h00;
        end
        if (mem_str) begin
            for (int i = 0; i < 4; i++)
                if (mem_sel[i]) memArr[mem_addr][8*i +: 8] <= mem_data_in[8*i +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Every cycle: the unit is ready exactly when no transaction is outstanding,
    // and never strobes store and load together.
    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("req_ready_vs_outstanding", {31'b0, req_ready}, {31'b0, !inFlight});
            checkOutput("str_ld_exclusive", {31'b0, mem_str & mem_ld}, 32'h0);
        end
    end

    function automatic int nBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit isFault(input logic [1:0] size, input logic [AB+1:0] addr);
`ifdef MISALIGN_TRAP_EN
        return (int'(addr) % nBytes(size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [AB+1:0] effAddr(input logic [1:0] size, input logic [AB+1:0] addr);
        int a;
        a = int'(addr);
        return (AB+2)'(a - (a % nBytes(size)));
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sgn, input logic [AB+1:0] addr);
        logic [31:0] v;
        int n;
        n = nBytes(size);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(refMem[int'(addr) + i]) << (8*i));
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [3:0] modelSel(input logic [1:0] size, input logic [AB+1:0] addr);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < nBytes(size); i++) s[(int'(addr) % 4) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] modelDataIn(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % nBytes(size)) +: 8];
        return d;
    endfunction

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [AB+1:0] addr, input logic [31:0] wdata, input int hold);
        logic [AB+1:0] ea;
        bit flt;
        int lat;
        logic [3:0]  expSel;
        logic [31:0] expDataIn, expRdata;
        ea = effAddr(size, addr);
        flt = isFault(size, addr);
        lat = flt ? 1 : (we ? 2 : 3);
        expSel = modelSel(size, ea);
        expDataIn = modelDataIn(size, wdata);
        expRdata = (flt || we) ? 32'h0 : modelLoad(size, sgn, ea);
        if (!flt && we) begin
            for (int i = 0; i < nBytes(size); i++) refMem[int'(ea) + i] = wdata[8*i +: 8];
        end
        dutSel = 'x; dutDataIn = 'x; dutAddr = 'x; dutRdata = 'x; dutMis = 'x;

        @(negedge clk);
        checkOutput("req_ready_before_accept", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        inFlight = 1'b1;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid = 1'b0;
                req_we = 1'($urandom);
                req_addr = (AB+2)'($urandom);
                req_wdata = $urandom;
            end
            if (n == 1 && !flt) begin
                checkOutput("mem_str_pulse", {31'b0, mem_str}, {31'b0, we});
                checkOutput("mem_ld_pulse", {31'b0, mem_ld}, {31'b0, !we});
                checkOutput("mem_sel", {28'b0, mem_sel}, {28'b0, expSel});
                checkOutput("mem_addr", 32'(mem_addr), 32'(ea >> 2));
                if (we) checkOutput("mem_data_in", mem_data_in, expDataIn);
                dutSel = mem_sel; dutDataIn = mem_data_in; dutAddr = mem_addr;
            end else begin
                checkOutput("strobes_quiet", {30'b0, mem_str, mem_ld}, 32'h0);
            end
            checkOutput("rsp_valid_latency", {31'b0, rsp_valid}, {31'b0, n == lat});
        end
        checkOutput("rsp_rdata", rsp_rdata, expRdata);
        checkOutput("rsp_misalign", {31'b0, rsp_misalign}, {31'b0, flt});
        dutRdata = rsp_rdata; dutMis = rsp_misalign;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            checkOutput("hold_rsp_rdata", rsp_rdata, expRdata);
            checkOutput("hold_rsp_misalign", {31'b0, rsp_misalign}, {31'b0, flt});
        end
        // A request waiting while the response completes must not be taken.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = (AB+2)'($urandom_range(0, 63));
        @(posedge clk);
        inFlight = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("rsp_valid_cleared", {31'b0, rsp_valid}, 32'h0);
        checkOutput("no_bypass_accept", {30'b0, mem_str, mem_ld}, 32'h0);
    endtask

    task automatic resetInWait(input logic [AB+1:0] addr);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = addr;
        @(posedge clk);
        inFlight = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        clr_n = 1'b0;
        @(posedge clk);
        inFlight = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        checkOutput("reset_wait_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("reset_wait_rsp_rdata", rsp_rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("reset_wait_no_response", {31'b0, rsp_valid}, 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) memArr[i] = '0;
        for (int i = 0; i < 4096; i++) refMem[i] = '0;

        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_misalign", {31'b0, rsp_misalign}, 32'h0);
        checkOutput("reset_strobes", {26'b0, mem_sel, mem_str, mem_ld}, 32'h0);
        clr_n = 1'b1;
        monEn = 1'b1;

        applyStimulus(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 0);
        checkOutput("store_word_sel", {28'b0, dutSel}, 32'hF);
        applyStimulus(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 0);
        checkOutput("load_word_sel", {28'b0, dutSel}, 32'hF);
        checkOutput("load_word_rdata", dutRdata, 32'hDEADBEEF);

        applyStimulus(1'b0, 2'd2, 1'b0, 12'h011, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
        checkOutput("misalign_flag", {31'b0, dutMis}, 32'h1);
        checkOutput("misalign_rdata", dutRdata, 32'h0);
`else
        checkOutput("misalign_forced_addr", 32'(dutAddr), 32'h4);
        checkOutput("misalign_forced_rdata", dutRdata, 32'hDEADBEEF);
        checkOutput("misalign_flag_tied", {31'b0, dutMis}, 32'h0);
`endif

        applyStimulus(1'b1, 2'd0, 1'b0, 12'h013, 32'h00000080, 0);
        checkOutput("store_byte_sel", {28'b0, dutSel}, 32'h8);
        checkOutput("store_byte_data_in", dutDataIn, 32'h80808080);
        applyStimulus(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 0);
        checkOutput("load_byte_signed", dutRdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 0);
        checkOutput("load_byte_unsigned", dutRdata, 32'h00000080);

        applyStimulus(1'b1, 2'd1, 1'b0, 12'h022, 32'h00008001, 0);
        applyStimulus(1'b0, 2'd1, 1'b1, 12'h022, 32'h0, 0);
        checkOutput("load_half_sel", {28'b0, dutSel}, 32'hC);
        checkOutput("load_half_signed", dutRdata, 32'hFFFF8001);

        applyStimulus(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 5);
        checkOutput("held_load_rdata", dutRdata, 32'h80ADBEEF);

        resetInWait(12'h010);

        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          (AB+2)'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3));
        end

        monEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
